// File: rtl/apb_arb_pkg.sv
// Shared definitions for the two-requester round-robin APB arbiter:
// state encoding, timeout defaults and the round-robin winner rule.
package apb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SETUP  = 2'b01,
    ST_ACCESS = 2'b10
  } arb_state_e;

  localparam int TIMEOUT_DEFAULT = 16;
  // Wide enough for the largest legal TIMEOUT (255).
  localparam int TCNT_W = 8;

  // The requester not served last wins a tie; a lone eligible requester always wins.
  function automatic logic rr_winner(input logic elig0, input logic elig1, input logic last_gnt);
    logic win;
    if (elig0 && elig1) begin
      win = ~last_gnt;
    end else if (elig1) begin
      win = 1'b1;
    end else begin
      win = 1'b0;
    end
    return win;
  endfunction

endpackage

// File: rtl/apb_rr_arbiter_if.sv
// Bundle of the requester-side and APB-side signals of apb_rr_arbiter.
// master = the arbiter; slave = the environment (requesters plus APB completer).
interface apb_rr_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);

  logic          req0;
  logic          req1;
  logic [AW-1:0] addr0;
  logic [AW-1:0] addr1;
  logic          write0;
  logic          write1;
  logic [DW-1:0] wdata0;
  logic [DW-1:0] wdata1;
  logic          ack0;
  logic          ack1;
  logic [DW-1:0] rdata0;
  logic [DW-1:0] rdata1;
  logic          err0;
  logic          err1;

  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata;
  logic          pready;
  logic          pslverr;

  logic          gnt;
  logic          busy;

  modport master (
    input  req0, req1, addr0, addr1, write0, write1, wdata0, wdata1,
    input  prdata, pready, pslverr,
    output ack0, ack1, rdata0, rdata1, err0, err1,
    output psel, penable, pwrite, paddr, pwdata,
    output gnt, busy
  );

  modport slave (
    output req0, req1, addr0, addr1, write0, write1, wdata0, wdata1,
    output prdata, pready, pslverr,
    input  ack0, ack1, rdata0, rdata1, err0, err1,
    input  psel, penable, pwrite, paddr, pwdata,
    input  gnt, busy
  );

endinterface

// File: rtl/apb_rr_arbiter_pick.sv
// Combinational round-robin winner selection between two eligible requesters.
module apb_rr_pick
  import apb_arb_pkg::*;
(
  input  logic elig0,
  input  logic elig1,
  input  logic last_gnt,
  output logic valid,
  output logic winner
);

  // Any eligible requester makes the pick valid; ties go to the one not served last.
  always_comb begin
    valid  = elig0 | elig1;
    winner = rr_winner(elig0, elig1, last_gnt);
  end

endmodule

// File: rtl/apb_rr_arbiter.sv
// Two-requester round-robin arbiter driving a single APB master port,
// with a per-transfer pready timeout that aborts and flags an error.
module apb_rr_arbiter
  import apb_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic               clk,
  input  logic               rstn,
  apb_rr_arbiter_if.master   bus
);

  localparam logic [TCNT_W-1:0] TCNT_LIMIT = TCNT_W'(TIMEOUT - 1);

  arb_state_e        state_r;
  logic              psel_r;
  logic              penable_r;
  logic              pwrite_r;
  logic [AW-1:0]     paddr_r;
  logic [DW-1:0]     pwdata_r;
  logic              gnt_r;
  logic              busy_r;
  logic [1:0]        ack_r;
  logic [1:0]        err_r;
  logic [DW-1:0]     rdata0_r;
  logic [DW-1:0]     rdata1_r;
  logic [TCNT_W-1:0] tcnt_r;

  logic              elig0_s;
  logic              elig1_s;
  logic              pick_valid_s;
  logic              pick_winner_s;
  logic [AW-1:0]     win_addr_s;
  logic              win_write_s;
  logic [DW-1:0]     win_wdata_s;

  // A requester whose ack is being pulsed this cycle is still holding its old req.
  always_comb begin
    elig0_s = bus.req0 & ~ack_r[0];
    elig1_s = bus.req1 & ~ack_r[1];
  end

  apb_rr_pick u_pick (
    .elig0    (elig0_s),
    .elig1    (elig1_s),
    .last_gnt (gnt_r),
    .valid    (pick_valid_s),
    .winner   (pick_winner_s)
  );

  // Steer the winning requester's transfer attributes toward the APB latches.
  always_comb begin
    if (pick_winner_s) begin
      win_addr_s  = bus.addr1;
      win_write_s = bus.write1;
      win_wdata_s = bus.wdata1;
    end else begin
      win_addr_s  = bus.addr0;
      win_write_s = bus.write0;
      win_wdata_s = bus.wdata0;
    end
  end

  // Transfer FSM with registered APB, ack/err/rdata and timeout counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r   <= ST_IDLE;
      psel_r    <= 1'b0;
      penable_r <= 1'b0;
      pwrite_r  <= 1'b0;
      paddr_r   <= '0;
      pwdata_r  <= '0;
      gnt_r     <= 1'b1;
      busy_r    <= 1'b0;
      ack_r     <= 2'b00;
      err_r     <= 2'b00;
      rdata0_r  <= '0;
      rdata1_r  <= '0;
      tcnt_r    <= '0;
    end else begin
      ack_r <= 2'b00;
      err_r <= 2'b00;
      case (state_r)
        ST_IDLE: begin
          if (pick_valid_s) begin
            state_r  <= ST_SETUP;
            gnt_r    <= pick_winner_s;
            paddr_r  <= win_addr_s;
            pwrite_r <= win_write_s;
            pwdata_r <= win_wdata_s;
            psel_r   <= 1'b1;
            busy_r   <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_SETUP: begin
          state_r   <= ST_ACCESS;
          penable_r <= 1'b1;
          tcnt_r    <= '0;
        end
        ST_ACCESS: begin
          if (bus.pready) begin
            state_r      <= ST_IDLE;
            psel_r       <= 1'b0;
            penable_r    <= 1'b0;
            busy_r       <= 1'b0;
            ack_r[gnt_r] <= 1'b1;
            err_r[gnt_r] <= bus.pslverr;
            if (!pwrite_r) begin
              if (gnt_r) begin
                rdata1_r <= bus.prdata;
              end else begin
                rdata0_r <= bus.prdata;
              end
            end
          end else if (tcnt_r == TCNT_LIMIT) begin
            // Completer never answered: abort with an error and cleared read data.
            state_r      <= ST_IDLE;
            psel_r       <= 1'b0;
            penable_r    <= 1'b0;
            busy_r       <= 1'b0;
            ack_r[gnt_r] <= 1'b1;
            err_r[gnt_r] <= 1'b1;
            if (gnt_r) begin
              rdata1_r <= '0;
            end else begin
              rdata0_r <= '0;
            end
          end else begin
            tcnt_r <= tcnt_r + TCNT_W'(1);
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          psel_r    <= 1'b0;
          penable_r <= 1'b0;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.psel    = psel_r;
  assign bus.penable = penable_r;
  assign bus.pwrite  = pwrite_r;
  assign bus.paddr   = paddr_r;
  assign bus.pwdata  = pwdata_r;
  assign bus.gnt     = gnt_r;
  assign bus.busy    = busy_r;
  assign bus.ack0    = ack_r[0];
  assign bus.ack1    = ack_r[1];
  assign bus.err0    = err_r[0];
  assign bus.err1    = err_r[1];
  assign bus.rdata0  = rdata0_r;
  assign bus.rdata1  = rdata1_r;

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Self-checking bench for apb_rr_arbiter: directed scenarios with literal
// expectations plus a transaction-level model compared on every clock.
module tb_apb_rr_arbiter;

  localparam int TIMEOUT = 16;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   wait_states = 0;

  apb_rr_arbiter_if #(.AW(32), .DW(32)) bus ();

  apb_rr_arbiter #(.TIMEOUT(TIMEOUT), .AW(32), .DW(32)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  // m_stage: 0 no transfer, 1 address phase, 2 data phase
  int          m_stage;
  int          m_waited;
  bit          m_gnt;
  logic [31:0] m_addr;
  bit          m_write;
  logic [31:0] m_wdata;
  bit   [1:0]  m_ack;
  bit   [1:0]  m_err;
  logic [31:0] m_rdata [2];

  task automatic m_reset();
    m_stage = 0; m_waited = 0; m_gnt = 1'b1;
    m_addr = 32'h0; m_write = 1'b0; m_wdata = 32'h0;
    m_ack = 2'b00; m_err = 2'b00;
    m_rdata[0] = 32'h0; m_rdata[1] = 32'h0;
  endtask

  task automatic m_finish(input bit e, input bit upd, input logic [31:0] rd);
    m_ack[m_gnt] = 1'b1;
    m_err[m_gnt] = e;
    if (upd) m_rdata[m_gnt] = rd;
    m_stage = 0;
  endtask

  task automatic m_step();
    bit e0, e1, w;
    e0 = bus.req0 && !m_ack[0];
    e1 = bus.req1 && !m_ack[1];
    m_ack = 2'b00;
    m_err = 2'b00;
    if (m_stage == 0) begin
      if (e0 || e1) begin
        w       = (e0 && e1) ? !m_gnt : e1;
        m_gnt   = w;
        m_addr  = w ? bus.addr1  : bus.addr0;
        m_write = w ? bus.write1 : bus.write0;
        m_wdata = w ? bus.wdata1 : bus.wdata0;
        m_stage = 1;
      end
    end else if (m_stage == 1) begin
      m_stage  = 2;
      m_waited = 0;
    end else begin
      m_waited++;
      if (bus.pready) m_finish(bus.pslverr, !m_write, bus.prdata);
      else if (m_waited == TIMEOUT) m_finish(1'b1, 1'b1, 32'h0);
    end
  endtask

  initial begin : model_cmp
    m_reset();
    forever begin
      @(posedge clk);
      if (!rstn) m_reset();
      else m_step();
      #1;
      chk("psel",    bus.psel,    m_stage != 0);
      chk("penable", bus.penable, m_stage == 2);
      chk("busy",    bus.busy,    m_stage != 0);
      chk("gnt",     bus.gnt,     m_gnt);
      chk("paddr",   bus.paddr,   m_addr);
      chk("pwrite",  bus.pwrite,  m_write);
      chk("pwdata",  bus.pwdata,  m_wdata);
      chk("ack0",    bus.ack0,    m_ack[0]);
      chk("ack1",    bus.ack1,    m_ack[1]);
      chk("err0",    bus.err0,    m_err[0]);
      chk("err1",    bus.err1,    m_err[1]);
      chk("rdata0",  bus.rdata0,  m_rdata[0]);
      chk("rdata1",  bus.rdata1,  m_rdata[1]);
    end
  end

  // APB completer: pready rises after wait_states data-phase cycles.
  initial begin : completer
    int acc;
    acc = 0;
    bus.pready = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.psel && bus.penable) acc++;
      else acc = 0;
      bus.pready = (acc > wait_states);
    end
  end

  task automatic wait_ack(input int port, input int limit, output int cycles);
    bit seen;
    seen = 1'b0;
    cycles = 0;
    while (!seen && cycles < limit) begin
      @(negedge clk);
      cycles++;
      seen = (port == 1) ? bus.ack1 : bus.ack0;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL ack_wait: no ack%0d within %0d cycles", port, limit);
    end
  endtask

  // ---------------- directed scenarios ----------------
  initial begin : main
    int cyc, n, t;
    int order [4];
    int ack_at [4];
    bit done;

    bus.req0 = 1'b0; bus.req1 = 1'b0;
    bus.addr0 = 32'h0; bus.addr1 = 32'h0;
    bus.write0 = 1'b0; bus.write1 = 1'b0;
    bus.wdata0 = 32'h0; bus.wdata1 = 32'h0;
    bus.prdata = 32'h0; bus.pslverr = 1'b0;
    for (int i = 0; i < 4; i++) begin order[i] = -1; ack_at[i] = 0; end

    repeat (3) @(negedge clk);
    chk("rst_psel", bus.psel, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_gnt",  bus.gnt,  1'b1);
    chk("rst_ack0", bus.ack0, 1'b0);
    chk("rst_rdata1", bus.rdata1, 32'h0);
    rstn = 1'b1;

    // Both requesters held high: alternating service starting with 0.
    @(negedge clk);
    bus.addr0 = 32'h100; bus.write0 = 1'b1; bus.wdata0 = 32'h11;
    bus.addr1 = 32'h200; bus.write1 = 1'b1; bus.wdata1 = 32'h22;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    n = 0; t = 0;
    while (n < 4 && t < 60) begin
      @(negedge clk);
      t++;
      if (bus.ack0 || bus.ack1) begin
        order[n]  = bus.ack1 ? 1 : 0;
        ack_at[n] = t;
        n++;
      end
    end
    bus.req0 = 1'b0; bus.req1 = 1'b0;
    chk("rr_count", n, 4);
    for (int i = 0; i < 4; i++) chk("rr_order", order[i], i % 2);
    for (int i = 1; i < 4; i++) chk("rr_gap", (ack_at[i] - ack_at[i-1]) >= 2, 1'b1);

    // Single write, zero wait states: T+1 / T+2 / T+3 timing.
    @(negedge clk);
    bus.addr0 = 32'h10; bus.write0 = 1'b1; bus.wdata0 = 32'hA5; bus.req0 = 1'b1;
    @(negedge clk);
    chk("wr_setup_psel", bus.psel, 1'b1);
    chk("wr_setup_pen",  bus.penable, 1'b0);
    chk("wr_paddr",      bus.paddr, 32'h10);
    chk("wr_pwrite",     bus.pwrite, 1'b1);
    chk("wr_pwdata",     bus.pwdata, 32'hA5);
    @(negedge clk);
    chk("wr_access_pen", bus.penable, 1'b1);
    @(negedge clk);
    chk("wr_ack0", bus.ack0, 1'b1);
    chk("wr_err0", bus.err0, 1'b0);
    chk("wr_done_psel", bus.psel, 1'b0);
    bus.req0 = 1'b0;

    // Read on requester 1 with three wait states.
    @(negedge clk);
    wait_states = 3; bus.prdata = 32'hDEADBEEF;
    bus.addr1 = 32'h20; bus.write1 = 1'b0; bus.req1 = 1'b1;
    cyc = 0; done = 1'b0;
    while (!done && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (bus.psel) chk("rd_paddr_hold", bus.paddr, 32'h20);
      done = bus.ack1;
    end
    chk("rd_latency", cyc, 6);
    chk("rd_rdata1", bus.rdata1, 32'hDEADBEEF);
    bus.req1 = 1'b0;

    // Slave error on a normal completion.
    @(negedge clk);
    wait_states = 0; bus.pslverr = 1'b1; bus.prdata = 32'h5555AAAA;
    bus.addr0 = 32'h30; bus.write0 = 1'b0; bus.req0 = 1'b1;
    wait_ack(0, 10, cyc);
    chk("slverr_latency", cyc, 3);
    chk("slverr_err0", bus.err0, 1'b1);
    chk("slverr_rdata0", bus.rdata0, 32'h5555AAAA);
    bus.req0 = 1'b0; bus.pslverr = 1'b0;

    // pready never comes: abort after TIMEOUT data-phase cycles.
    @(negedge clk);
    wait_states = 1000; bus.prdata = 32'h77; bus.req0 = 1'b1;
    wait_ack(0, 40, cyc);
    chk("tmo_latency", cyc, 18);
    chk("tmo_err0", bus.err0, 1'b1);
    chk("tmo_rdata0", bus.rdata0, 32'h0);
    bus.req0 = 1'b0;

    // pready arrives exactly on the timeout-limit cycle: normal completion.
    @(negedge clk);
    wait_states = TIMEOUT - 1; bus.prdata = 32'h600D; bus.req0 = 1'b1;
    wait_ack(0, 40, cyc);
    chk("edge_latency", cyc, 18);
    chk("edge_err0", bus.err0, 1'b0);
    chk("edge_rdata0", bus.rdata0, 32'h600D);
    bus.req0 = 1'b0;

    // Reset in the middle of a data phase, then a fresh request from 1.
    @(negedge clk);
    wait_states = 1000; bus.req0 = 1'b1;
    repeat (3) @(negedge clk);
    chk("prerst_pen", bus.penable, 1'b1);
    chk("prerst_gnt", bus.gnt, 1'b0);
    #2 rstn = 1'b0;
    #1;
    chk("arst_psel", bus.psel, 1'b0);
    chk("arst_pen",  bus.penable, 1'b0);
    chk("arst_busy", bus.busy, 1'b0);
    chk("arst_ack0", bus.ack0, 1'b0);
    chk("arst_gnt",  bus.gnt, 1'b1);
    @(negedge clk);
    bus.req0 = 1'b0;
    wait_states = 0; bus.prdata = 32'h0BADF00D;
    bus.addr1 = 32'h44; bus.write1 = 1'b0; bus.req1 = 1'b1;
    rstn = 1'b1;
    wait_ack(1, 10, cyc);
    chk("post_latency", cyc, 3);
    chk("post_rdata1", bus.rdata1, 32'h0BADF00D);
    chk("post_gnt", bus.gnt, 1'b1);
    bus.req1 = 1'b0;

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
